rsa_job_driver: RTL and testbench

- Initiator side of the RSA core's start/done handshake.
- Accepts plaintext/ciphertext words on a valid/ready input stream and latches key and modulus per job.
- Pulses core_start, waits for core_done with a timeout watchdog, captures core_result and presents it on a valid/ready output stream with an error flag.
- Sits between the board-level data source and rsa_top in the FPGA top, replacing direct pin drive of start/data.

---
 rtl/rsa_job_driver.sv | 140 ++++++++++++++
 tb/tb_rsa_job_driver.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_driver.sv
// Initiator for the RSA core start/done handshake: latches one job from a valid/ready
// input stream, starts the core, watches for done with a timeout, and returns the result.
module rsa_job_driver #(
    parameter int W   = 6,
    parameter int TMO = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] in_key,
    input  logic [W-1:0] in_n,
    output logic         core_start,
    output logic [W-1:0] core_key,
    output logic [W-1:0] core_data,
    output logic [W-1:0] core_n,
    input  logic         core_done,
    input  logic [W-1:0] core_result,
    output logic         core_abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_err,
    output logic [15:0]  job_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_MODULUS = 2'b11;

    state_t      state;
    state_t      state_nx;
    logic [15:0] tmo_cnt;
    logic        accept;
    logic        n_small;
    logic        data_big;
    logic        tmo_hit;

    // in_ready also drops while rst is high so nothing is accepted in a reset cycle.
    assign in_ready   = (state == IDLE) && !rst;
    assign core_start = (state == ISSUE);
    assign out_valid  = (state == HOLD);

    assign accept   = in_valid && in_ready;
    assign n_small  = in_n < W'(2);
    assign data_big = in_data >= in_n;
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (n_small || data_big) begin
                        state_nx = HOLD;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (core_done || tmo_hit) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            core_key   <= '0;
            core_data  <= '0;
            core_n     <= '0;
            core_abort <= 1'b0;
            out_data   <= '0;
            out_err    <= ERR_OK;
            job_cnt    <= '0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_nx;
            core_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        core_key  <= in_key;
                        core_data <= in_data;
                        core_n    <= in_n;
                        if (n_small) begin
                            out_err  <= ERR_MODULUS;
                            out_data <= '0;
                        end else if (data_big) begin
                            out_err  <= ERR_RANGE;
                            out_data <= in_data;
                        end
                    end
                end
                ISSUE: tmo_cnt <= '0;
                WAIT: begin
                    // done takes priority over a timeout landing on the same edge
                    if (core_done) begin
                        out_data <= core_result;
                        out_err  <= ERR_OK;
                    end else if (tmo_hit) begin
                        out_data   <= '0;
                        out_err    <= ERR_TIMEOUT;
                        core_abort <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        job_cnt <= job_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_driver.sv
// Bench for rsa_job_driver: a behavioural RSA core answers core_start after a chosen
// delay, and each job's outcome is predicted from the data/key/modulus rules alone.
module tb_rsa_job_driver;

    localparam int W   = 6;
    localparam int TMO = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] in_key;
    logic [W-1:0] in_n;
    logic         core_start;
    logic [W-1:0] core_key;
    logic [W-1:0] core_data;
    logic [W-1:0] core_n;
    logic         core_done;
    logic [W-1:0] core_result;
    logic         core_abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_err;
    logic [15:0]  job_cnt;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [15:0]  exp_cnt = '0;
    logic [W+1:0] exp_q[$];
    int           core_lat = 0;
    bit           core_issue_pulse = 1'b0;

    always #5 clk = ~clk;

    rsa_job_driver #(.W(W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .in_n(in_n),
        .core_start(core_start), .core_key(core_key),
        .core_data(core_data), .core_n(core_n),
        .core_done(core_done), .core_result(core_result),
        .core_abort(core_abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .job_cnt(job_cnt)
    );

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        int r;
        if (m < 2) return '0;
        r = 1;
        for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(m);
        return W'(r);
    endfunction

    // Core model: done rises core_lat cycles after the start cycle (0 = never answers).
    initial begin
        int lat_l;
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (core_start) begin
                lat_l = core_lat;
                if (core_issue_pulse) begin
                    core_done   = 1'b1;
                    core_result = W'($urandom);
                end
                if (lat_l > 0) begin
                    for (int i = 0; i < lat_l; i++) begin
                        @(negedge clk);
                        core_done = 1'b0;
                    end
                    core_done   = 1'b1;
                    core_result = modexp(core_data, core_key, core_n);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end want summary");
        $fatal(1, "watchdog");
    end

    // One complete job: accept, observe core traffic and result, optional stall, handshake.
    task automatic run_job(input logic [W-1:0] d, input logic [W-1:0] k, input logic [W-1:0] n,
                           input int lat, input bit pulse, input int hold_cyc, input bit poke);
        logic [W+1:0] exp;
        logic [W+1:0] want;
        int           exp_lat, c, starts, start_cyc, aborts;
        bit           exp_core, exp_to, hold_ok;
        exp_core = 1'b0;
        exp_to   = 1'b0;
        if (n < 2) begin
            exp = {2'b11, {W{1'b0}}}; exp_lat = 1;
        end else if (d >= n) begin
            exp = {2'b01, d}; exp_lat = 1;
        end else begin
            exp_core = 1'b1;
            if (lat >= 1 && lat <= TMO) begin
                exp = {2'b00, modexp(d, k, n)}; exp_lat = lat + 2;
            end else begin
                exp = {2'b10, {W{1'b0}}}; exp_lat = TMO + 2; exp_to = 1'b1;
            end
        end
        exp_q.push_back(exp);
        core_lat         = lat;
        core_issue_pulse = pulse;

        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL in_ready_idle: got %b want 1", in_ready);
        end
        in_valid = 1'b1; in_data = d; in_key = k; in_n = n;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom); in_key = W'($urandom); in_n = W'($urandom);

        starts = 0; aborts = 0; start_cyc = 0; c = 1;
        while (out_valid !== 1'b1 && c <= TMO + 8) begin
            if (core_start === 1'b1) begin
                starts++; start_cyc = c;
                n_cmp++;
                if ({core_key, core_data, core_n} !== {k, d, n}) begin
                    n_bad++;
                    $display("FAIL core_regs: got %h/%h/%h want %h/%h/%h",
                             core_key, core_data, core_n, k, d, n);
                end
            end
            if (core_abort === 1'b1) aborts++;
            @(negedge clk);
            c++;
        end
        if (core_start === 1'b1) starts++;
        if (core_abort === 1'b1) aborts++;

        n_cmp++;
        if (out_valid !== 1'b1 || c != exp_lat) begin
            n_bad++; $display("FAIL out_latency: got %0d cycles (valid=%b) want %0d", c, out_valid, exp_lat);
        end
        n_cmp++;
        if (starts != int'(exp_core) || (exp_core && start_cyc != 1)) begin
            n_bad++; $display("FAIL core_start: got %0d pulses at cycle %0d want %0d at cycle 1",
                              starts, start_cyc, exp_core);
        end
        n_cmp++;
        if (core_abort !== exp_to) begin
            n_bad++; $display("FAIL abort_first_hold: got %b want %b", core_abort, exp_to);
        end
        want = exp_q.pop_front();
        n_cmp++;
        if ({out_err, out_data} !== want) begin
            n_bad++; $display("FAIL result: got err=%b data=%0d want err=%b data=%0d",
                              out_err, out_data, want[W+1:W], want[W-1:0]);
        end

        hold_ok = 1'b1;
        for (int i = 0; i < hold_cyc; i++) begin
            if (poke) begin
                in_valid = 1'b1; in_data = W'($urandom); in_key = W'($urandom); in_n = W'($urandom);
            end
            @(negedge clk);
            if (core_abort === 1'b1) aborts++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || core_start !== 1'b0 ||
                {out_err, out_data} !== want) hold_ok = 1'b0;
        end
        if (hold_cyc > 0) begin
            n_cmp++;
            if (!hold_ok) begin
                n_bad++; $display("FAIL hold_stable: got err=%b data=%0d in_ready=%b want err=%b data=%0d in_ready=0",
                                  out_err, out_data, in_ready, want[W+1:W], want[W-1:0]);
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (core_abort === 1'b1) aborts++;
        exp_cnt++;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL after_handshake: got valid=%b ready=%b want valid=0 ready=1",
                              out_valid, in_ready);
        end
        n_cmp++;
        if (job_cnt !== exp_cnt) begin
            n_bad++; $display("FAIL job_cnt: got %0h want %0h", job_cnt, exp_cnt);
        end
        n_cmp++;
        if (aborts != int'(exp_to)) begin
            n_bad++; $display("FAIL abort_count: got %0d want %0d", aborts, exp_to);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        n_cmp++;
        if ({core_start, core_abort, out_valid, core_key, core_data, core_n, out_data, out_err, job_cnt} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got start=%b abort=%b valid=%b data=%0d err=%b cnt=%0d want all 0",
                              core_start, core_abort, out_valid, out_data, out_err, job_cnt);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        exp_cnt = '0;
    endtask

    task automatic test_normal();
        run_job(6'd4, 6'd7, 6'd33, 20, 1'b0, 0, 1'b0);
    endtask

    task automatic test_errors();
        run_job(6'd40, 6'd3, 6'd33, 5, 1'b0, 0, 1'b0);
        run_job(6'd0, 6'd3, 6'd1, 5, 1'b0, 0, 1'b0);
        run_job(6'd5, 6'd3, 6'd0, 5, 1'b0, 0, 1'b0);
        run_job(6'd33, 6'd3, 6'd33, 5, 1'b0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_job(6'd10, 6'd5, 6'd33, 0, 1'b0, 0, 1'b0);
        run_job(6'd10, 6'd5, 6'd33, 3, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_pressure();
        run_job(6'd9, 6'd11, 6'd50, 7, 1'b0, 50, 1'b1);
        run_job(6'd60, 6'd1, 6'd20, 1, 1'b0, 50, 1'b1);
    endtask

    task automatic test_done_edges();
        run_job(6'd12, 6'd9, 6'd61, 5, 1'b1, 0, 1'b0);
        run_job(6'd7, 6'd13, 6'd55, TMO, 1'b0, 2, 1'b0);
        run_job(6'd7, 6'd13, 6'd55, TMO + 1, 1'b0, 0, 1'b0);
        run_job(6'd3, 6'd2, 6'd5, 1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_job(W'($urandom), W'($urandom), W'($urandom_range(0, 63)),
                    $urandom_range(0, TMO + 2), 1'(($urandom_range(0, 3) == 0)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_job(W'($urandom_range(0, 20)), W'($urandom), W'($urandom_range(21, 63)),
                    $urandom_range(1, 4), 1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        bit quiet;
        core_lat = 12; core_issue_pulse = 1'b0;
        in_valid = 1'b1; in_data = 6'd4; in_key = 6'd7; in_n = 6'd33;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({core_start, core_abort, out_valid, core_key, core_data, core_n, out_data, out_err, job_cnt} !== '0
            || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset_outputs: got start=%b valid=%b key=%0d data=%0d n=%0d cnt=%0d ready=%b want zeros ready=1",
                              core_start, out_valid, core_key, core_data, core_n, job_cnt, in_ready);
        end
        exp_cnt = '0;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || core_start !== 1'b0 || core_abort !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet || job_cnt !== 16'd0) begin
            n_bad++; $display("FAIL late_done_ignored: got quiet=%b cnt=%0d want quiet=1 cnt=0", quiet, job_cnt);
        end
    endtask

    task automatic test_wrap();
        force dut.job_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.job_cnt;
        exp_cnt = 16'hFFFE;
        run_job(6'd50, 6'd1, 6'd10, 1, 1'b0, 0, 1'b0);
        run_job(6'd50, 6'd1, 6'd10, 1, 1'b0, 0, 1'b0);
        run_job(6'd2, 6'd3, 6'd10, 2, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; in_n = '0; out_ready = 1'b0;
        test_reset();
        test_normal();
        test_errors();
        test_timeout();
        test_back_pressure();
        test_done_edges();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
